// File: rtl/ram_fifo_ctrl.sv
//------------------------------------------------------------------------------
// Module      : ram_fifo_ctrl
// Description : FIFO controller around a 1-cycle-latency single-clock RAM,
//               with a 2-entry first-word-fall-through output buffer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  ram_wr_enb,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_enb,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_ram_cnt;
  logic                  r_rd_inflight;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic [1:0]            r_occ;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_rd_issue;
  logic [2:0]            w_credit;
  logic [1:0]            w_slot;

  assign in_ready   = (r_ram_cnt != c_depth);
  assign out_valid  = (r_occ != 2'd0);
  assign out_data   = r_buf0;
  assign w_push     = in_valid & in_ready;
  assign w_pop      = out_valid & out_ready;

  // Buffer slots already claimed after this cycle's pop; a read may only be
  // issued when one slot will still be free when its data lands.
  assign w_credit   = {1'b0, r_occ} + {2'b00, r_rd_inflight} - {2'b00, w_pop};
  assign w_rd_issue = (r_ram_cnt != '0) & (w_credit < 3'd2);
  assign w_slot     = r_occ - {1'b0, w_pop};

  assign ram_wr_enb  = w_push;
  assign ram_wr_addr = r_wr_ptr;
  assign ram_wr_data = in_data;
  assign ram_rd_enb  = w_rd_issue;
  assign ram_rd_addr = r_rd_ptr;

  assign level = r_ram_cnt + (ADDR_WIDTH+1)'(r_rd_inflight) + (ADDR_WIDTH+1)'(r_occ);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_ram_cnt     <= '0;
      r_rd_inflight <= 1'b0;
      r_occ         <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_rd_issue) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      case ({w_push, w_rd_issue})
        2'b10:   r_ram_cnt <= r_ram_cnt + (ADDR_WIDTH+1)'(1);
        2'b01:   r_ram_cnt <= r_ram_cnt - (ADDR_WIDTH+1)'(1);
        default: r_ram_cnt <= r_ram_cnt;
      endcase
      r_rd_inflight <= w_rd_issue;
      r_occ         <= w_slot + {1'b0, r_rd_inflight};
    end
  end

  // A capture into slot 0 overrides the shift of buf1 in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      if (w_pop) begin
        r_buf0 <= r_buf1;
      end
      if (r_rd_inflight) begin
        if (w_slot == 2'd0) begin
          r_buf0 <= ram_rd_data;
        end else begin
          r_buf1 <= ram_rd_data;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
Synchronous FIFO controller that uses the 16x8 single-clock RAM as its storage array. It drives the RAM write and read ports and absorbs the RAM's 1-cycle registered read latency. A 2-entry output buffer presents a first-word-fall-through valid/ready stream. It sits directly upstream of the RAM and downstream of any producer that needs buffered 8-bit transport.

Parameters:
DATA_WIDTH, 8, data word width; must match the RAM.
ADDR_WIDTH, 4, RAM address width.
DEPTH, 16, RAM entries; equals 2**ADDR_WIDTH.

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  producer has a word.
in_ready  output  1  controller accepts a word this cycle.
in_data  input  DATA_WIDTH  producer word.
out_valid  output  1  out_data holds a valid word.
out_ready  input  1  consumer takes out_data this cycle.
out_data  output  DATA_WIDTH  head-of-FIFO word.
level  output  ADDR_WIDTH+1  total words held: RAM, in flight and output buffer (0..DEPTH+2).
ram_wr_enb  output  1  to RAM wr_enb.
ram_wr_addr  output  ADDR_WIDTH  to RAM wr_addr.
ram_wr_data  output  DATA_WIDTH  to RAM wr_data.
ram_rd_enb  output  1  to RAM rd_enb.
ram_rd_addr  output  ADDR_WIDTH  to RAM rd_addr.
ram_rd_data  input  DATA_WIDTH  from RAM rd_data; valid one cycle after ram_rd_enb.

Behaviour:
- State registers:
  - wr_ptr and rd_ptr, each ADDR_WIDTH bits, wrapping DEPTH-1 -> 0.
  - ram_cnt, 0..DEPTH.
  - rd_inflight, 1 bit.
  - buf0 and buf1, each DATA_WIDTH bits.
  - occ, 0..2.
- Reset: all the above cleared to 0. Outputs after the reset edge: out_valid=0, out_data=0, in_ready=1, level=0, ram_wr_enb=0, ram_rd_enb=0. rst also clears the RAM contents and its rd_data, since it is the same reset net.
- Reset mid-operation discards all data. No partial state survives.
- Push:
  - in_ready = (ram_cnt != DEPTH), from registered state only.
  - On in_valid & in_ready: ram_wr_enb=1, ram_wr_addr=wr_ptr, ram_wr_data=in_data; wr_ptr increments.
  - The RAM port signals are combinational from in_valid, in_ready and the pointers.
- RAM read issue:
  - pop = out_valid & out_ready.
  - ram_rd_enb = (ram_cnt != 0) & ((occ + rd_inflight - pop) < 2).
  - ram_rd_addr = rd_ptr. On issue, rd_ptr increments and rd_inflight is set for the next cycle.
- ram_cnt update: +1 on push, -1 on read issue, unchanged when both happen in the same cycle.
- Capture:
  - In a cycle with rd_inflight=1, ram_rd_data is written at the edge into slot (occ - pop): buf0 if that value is 0, buf1 if it is 1.
  - The credit rule guarantees a free slot, so no word is dropped.
- Output:
  - out_valid = (occ != 0); out_data = buf0.
  - On pop, buf1 shifts into buf0 and occ decrements, except where a capture refills it in the same cycle.
- level = ram_cnt + rd_inflight + occ, registered-consistent with the state.
- Latency: a word pushed in cycle N is read-issued in N+1, in flight in N+2, and shown with out_valid=1 in N+3.
- Throughput: sustained 1 word/cycle with in_valid=out_ready=1.
- Capacity is DEPTH+2 = 18 words. in_ready deasserts only when ram_cnt==DEPTH.
- Same-address RAM write and read in one cycle cannot occur: a write needs ram_cnt<DEPTH, and equal pointers with a read needs ram_cnt==DEPTH.
- Simultaneous push and pop at any fill level: both honoured in the same cycle.
- Order is strictly FIFO. There is no bypass path around the RAM.

Test Plan:
1. Assert rst for 2 cycles -> out_valid=0, in_ready=1, level=0, ram_wr_enb=0, ram_rd_enb=0; all RAM locations read 0x00.
2. Single push 0xA5 in cycle 0 with out_ready=1 -> ram_wr_addr=0 in cycle 0; ram_rd_enb=1 with ram_rd_addr=0 in cycle 1; out_valid=1 with out_data=0xA5 in cycle 3 only; level returns to 0 in cycle 4.
3. Fill with out_ready=0, pushing 0x00,0x01,... continuously -> exactly 18 words accepted, then in_ready=0 and level=18. Then out_ready=1 -> outputs 0x00..0x11 in order, one per cycle; in_ready returns to 1 one cycle after the first pop frees RAM space.
4. Stream for 40 cycles with in_valid=out_ready=1 and incrementing data -> after 3-cycle latency, out_data increments every cycle with no gaps; both RAM addresses wrap 0xF->0x0 twice; level stays at 3.
5. Random in_valid and random out_ready for 500 cycles against a scoreboard -> no loss, duplication or reorder; level never exceeds 18; ram_wr_enb never asserted while ram_cnt==16.
6. With level=10, assert rst for one cycle -> next cycle out_valid=0 and level=0. Then push 0x3C -> 0x3C is the first output, 3 cycles later.
